alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu_add16.sv | 12 +
 rtl/alu.sv | 117 +++++++++++
 tb/tb_alu.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes and default width for the alu block
package alu_pkg;
    localparam int ALU_WIDTH = 16;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;
endpackage

// File: rtl/alu_add16.sv
// rtl/alu_add16.sv - WIDTH-bit adder with carry-in and carry-out
module alu_add16 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);
    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
endmodule

// File: rtl/alu.sv
// rtl/alu.sv - registered ALU with flags plus an independent branch adder
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [2:0]       ctrl,
    input  logic [WIDTH-1:0] add_a,
    input  logic [WIDTH-1:0] add_b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cin,
    output logic             vin,
    output logic             sin,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    localparam int SHW = $clog2(WIDTH);

    logic             w_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_alu_sum;
    logic             w_alu_cout;
    logic [WIDTH-1:0] w_br_sum;
    logic             w_br_cout;
    logic             w_ovf;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_res;
    logic             w_cin;
    logic             w_vin;

    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_cin;
    logic             r_vin;
    logic             r_sin;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;

    // SUB and SLT share the adder as src1 + ~src2 + 1
    assign w_sub   = (ctrl == OP_SUB) || (ctrl == OP_SLT);
    assign w_b_eff = w_sub ? ~src2 : src2;
    assign w_shamt = src2[SHW-1:0];

    alu_add16 #(.WIDTH(WIDTH)) u_alu_add (
        .i_a    (src1),
        .i_b    (w_b_eff),
        .i_cin  (w_sub),
        .o_sum  (w_alu_sum),
        .o_cout (w_alu_cout)
    );

    alu_add16 #(.WIDTH(WIDTH)) u_br_add (
        .i_a    (add_a),
        .i_b    (add_b),
        .i_cin  (1'b0),
        .o_sum  (w_br_sum),
        .o_cout (w_br_cout)
    );

    // Overflow: both adder inputs share a sign that the sum does not
    assign w_ovf = (src1[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                   (w_alu_sum[WIDTH-1] != src1[WIDTH-1]);

    always_comb begin
        w_res = '0;
        w_cin = 1'b0;
        w_vin = 1'b0;
        case (ctrl)
            OP_AND: w_res = src1 & src2;
            OP_OR:  w_res = src1 | src2;
            OP_XOR: w_res = src1 ^ src2;
            OP_SLL: w_res = src1 << w_shamt;
            OP_SRL: w_res = src1 >> w_shamt;
            OP_ADD, OP_SUB: begin
                w_res = w_alu_sum;
                w_cin = w_alu_cout;
                w_vin = w_ovf;
            end
            OP_SLT: w_res = {{(WIDTH-1){1'b0}}, w_alu_sum[WIDTH-1] ^ w_ovf};
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_zero   <= 1'b1;
            r_cin    <= 1'b0;
            r_vin    <= 1'b0;
            r_sin    <= 1'b0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
        end else if (en) begin
            r_result <= w_res;
            r_zero   <= (w_res == '0);
            r_cin    <= w_cin;
            r_vin    <= w_vin;
            r_sin    <= w_res[WIDTH-1];
            r_sum    <= w_br_sum;
            r_carry  <= w_br_cout;
        end
    end

    assign result = r_result;
    assign zero   = r_zero;
    assign cin    = r_cin;
    assign vin    = r_vin;
    assign sin    = r_sin;
    assign sum    = r_sum;
    assign carry  = r_carry;
endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - randomized self-checking bench for alu against an arithmetic model
module tb_alu;
    import alu_pkg::*;

    typedef struct {
        logic [15:0] res;
        logic        z;
        logic        c;
        logic        v;
        logic        s;
        logic [15:0] sum;
        logic        carry;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] src1;
    logic [15:0] src2;
    logic [2:0]  ctrl;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic [15:0] result;
    logic        zero;
    logic        cin;
    logic        vin;
    logic        sin;
    logic [15:0] sum;
    logic        carry;

    int   n_checks;
    int   n_errors;
    exp_t exp_q;

    alu #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .src1   (src1),
        .src2   (src2),
        .ctrl   (ctrl),
        .add_a  (add_a),
        .add_b  (add_b),
        .result (result),
        .zero   (zero),
        .cin    (cin),
        .vin    (vin),
        .sin    (sin),
        .sum    (sum),
        .carry  (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference computed from the arithmetic meaning of each operation
    function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                   input logic [15:0] aa, input logic [15:0] ab);
        exp_t        r;
        int          ua, ub, sa, sb, sh;
        logic [31:0] t;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        sh = ub % 16;
        r.c = 1'b0;
        r.v = 1'b0;
        t = 32'h0;
        case (op)
            3'b000: t = ua & ub;
            3'b001: t = ua | ub;
            3'b011: t = ua ^ ub;
            3'b100: t = ua << sh;
            3'b101: t = ua >> sh;
            3'b010: begin
                t   = ua + ub;
                r.c = (ua + ub) > 65535;
                r.v = ((sa + sb) > 32767) || ((sa + sb) < -32768);
            end
            3'b110: begin
                t   = ua - ub;
                r.c = (ua >= ub);
                r.v = ((sa - sb) > 32767) || ((sa - sb) < -32768);
            end
            default: t = (sa < sb) ? 1 : 0;
        endcase
        r.res = t[15:0];
        r.z   = (r.res == 16'h0);
        r.s   = r.res[15];
        t     = int'(aa) + int'(ab);
        r.sum   = t[15:0];
        r.carry = t[16];
        return r;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".result"}, 32'(result), 32'(exp_q.res));
        check({tag, ".zero"},   32'(zero),   32'(exp_q.z));
        check({tag, ".cin"},    32'(cin),    32'(exp_q.c));
        check({tag, ".vin"},    32'(vin),    32'(exp_q.v));
        check({tag, ".sin"},    32'(sin),    32'(exp_q.s));
        check({tag, ".sum"},    32'(sum),    32'(exp_q.sum));
        check({tag, ".carry"},  32'(carry),  32'(exp_q.carry));
    endtask

    task automatic set_reset_exp();
        exp_q.res = 16'h0; exp_q.z = 1'b1; exp_q.c = 1'b0; exp_q.v = 1'b0;
        exp_q.s = 1'b0; exp_q.sum = 16'h0; exp_q.carry = 1'b0;
    endtask

    task automatic step(input string tag, input logic e, input logic [2:0] op,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] aa, input logic [15:0] ab);
        @(negedge clk);
        en = e; ctrl = op; src1 = a; src2 = b; add_a = aa; add_b = ab;
        @(posedge clk);
        #1;
        if (e) exp_q = model(op, a, b, aa, ab);
        check_outputs(tag);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b1; en = 1'b0; ctrl = OP_AND;
        src1 = 16'h0; src2 = 16'h0; add_a = 16'h0; add_b = 16'h0;
        #1 rst_n = 1'b0;
        set_reset_exp();
        repeat (2) @(posedge clk);
        #1 check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        step("add_wrap",  1'b1, OP_ADD, 16'hFFFF, 16'h0001, 16'h0010, 16'hFFF8);
        check("add_wrap.lit_res", 32'(result), 32'h0);
        check("add_wrap.lit_cin", 32'(cin), 32'h1);
        check("br.lit_sum", 32'(sum), 32'h0008);
        check("br.lit_carry", 32'(carry), 32'h1);
        step("sub_ovf",   1'b1, OP_SUB, 16'h8000, 16'h0001, 16'h0000, 16'h0000);
        check("sub_ovf.lit_res", 32'(result), 32'h7FFF);
        check("sub_ovf.lit_vin", 32'(vin), 32'h1);
        step("slt_lt",    1'b1, OP_SLT, 16'hFFFE, 16'h0003, 16'h1234, 16'h4321);
        check("slt_lt.lit_res", 32'(result), 32'h1);
        step("slt_ge",    1'b1, OP_SLT, 16'h0003, 16'hFFFE, 16'h1234, 16'h4321);
        check("slt_ge.lit_zero", 32'(zero), 32'h1);
        step("and",       1'b1, OP_AND, 16'hF0F0, 16'h0FF0, 16'h0001, 16'h0001);
        check("and.lit_res", 32'(result), 32'h00F0);
        step("sll15",     1'b1, OP_SLL, 16'h0001, 16'h000F, 16'h0001, 16'h0001);
        check("sll15.lit_sin", 32'(sin), 32'h1);
        step("srl4",      1'b1, OP_SRL, 16'h8000, 16'h0004, 16'h0001, 16'h0001);
        check("srl4.lit_res", 32'(result), 32'h0800);
        step("hold",      1'b0, OP_XOR, 16'hAAAA, 16'h5555, 16'hFFFF, 16'hFFFF);
        step("hold2",     1'b0, OP_ADD, 16'h1234, 16'h0000, 16'h8000, 16'h8000);

        // Async reset pulse between edges, then a pending load discarded by reset
        @(negedge clk);
        en = 1'b1; ctrl = OP_OR; src1 = 16'h00FF; src2 = 16'h0F00; add_a = 16'h7000; add_b = 16'h9001;
        #1 rst_n = 1'b0;
        #1 set_reset_exp();
        check_outputs("rst_pulse");
        @(posedge clk);
        #1 check_outputs("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 exp_q = model(OP_OR, 16'h00FF, 16'h0F00, 16'h7000, 16'h9001);
        check_outputs("first_load");

        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                 pick(), pick(), pick(), pick());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
